// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: takes a word over valid/ready and emits it one bit per clock.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             ser_hold,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LastCnt = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_out_d;
  logic             last_bit;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Bit that goes on the line next, and the word with that bit consumed.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      ser_out_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      ser_out_q <= ser_out_d;
`ifdef SER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    ser_out_d = ser_out_q;
`ifdef SER_PARITY_EN
    par_d     = par_q;
`endif

    last_bit = (state_q == StShift) && (cnt_q == LastCnt);
`ifdef SER_PARITY_EN
    done = (state_q == StParity);
`else
    done = last_bit;
`endif
    // A new word may load on the same edge the final frame bit retires.
    din_ready = (state_q == StIdle) || (done && !ser_hold);
    accept    = din_valid && din_ready;

    if (accept) begin
      state_d   = StShift;
      shreg_d   = advance(din);
      cnt_d     = '0;
      ser_out_d = head_bit(din);
`ifdef SER_PARITY_EN
      par_d     = ^din;
`endif
    end else if (!ser_hold) begin
      case (state_q)
        StShift: begin
          if (last_bit) begin
`ifdef SER_PARITY_EN
            state_d   = StParity;
            ser_out_d = par_q;
`else
            state_d   = StIdle;
            ser_out_d = 1'b0;
`endif
          end else begin
            ser_out_d = head_bit(shreg_q);
            shreg_d   = advance(shreg_q);
            cnt_d     = cnt_q + CW'(1);
          end
        end
`ifdef SER_PARITY_EN
        StParity: begin
          state_d   = StIdle;
          ser_out_d = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = (state_q != StIdle);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances checked every cycle
// against a frame-queue model; honours SER_PARITY_EN when defined.
module tb_serial_bit_feeder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         ser_hold;

  logic m_ready, m_out, m_valid, m_busy, m_done;
  logic l_ready, l_out, l_valid, l_busy, l_done;

  int total = 0;
  int bad   = 0;

  // Frame bits still to be shown; element 0 is the bit currently on the line.
  bit q_msb[$];
  bit q_lsb[$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(m_ready),
    .ser_hold(ser_hold), .ser_out(m_out), .ser_valid(m_valid), .busy(m_busy), .done(m_done)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .ser_hold(ser_hold), .ser_out(l_out), .ser_valid(l_valid), .busy(l_busy), .done(l_done)
  );

  task automatic chk(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input logic hold);
    logic act, exp_ready, exp_done;
    act       = (q_msb.size() > 0);
    exp_done  = (q_msb.size() == 1);
    exp_ready = !act || (exp_done && !hold);
    chk("msb_ready", m_ready, exp_ready);
    chk("msb_valid", m_valid, act);
    chk("msb_busy",  m_busy,  act);
    chk("msb_done",  m_done,  exp_done);
    chk("msb_out",   m_out,   act ? logic'(q_msb[0]) : 1'b0);
    chk("lsb_ready", l_ready, exp_ready);
    chk("lsb_valid", l_valid, act);
    chk("lsb_done",  l_done,  exp_done);
    chk("lsb_out",   l_out,   act ? logic'(q_lsb[0]) : 1'b0);
  endtask

  task automatic cycle(input logic v, input logic [W-1:0] d, input logic h);
    logic acc;
    din_valid = v;
    din       = d;
    ser_hold  = h;
    @(negedge clk);
    check_all(h);
    acc = v && ((q_msb.size() == 0) || (q_msb.size() == 1 && !h));
    @(posedge clk);
    if (acc) begin
      q_msb.delete();
      q_lsb.delete();
      for (int i = 0; i < int'(W); i++) begin
        q_msb.push_back(d[W-1-i]);
        q_lsb.push_back(d[i]);
      end
`ifdef SER_PARITY_EN
      q_msb.push_back(^d);
      q_lsb.push_back(^d);
`endif
    end else if (q_msb.size() > 0 && !h) begin
      void'(q_msb.pop_front());
      void'(q_lsb.pop_front());
    end
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear before any edge.
  task automatic async_reset();
    rst = 1'b1;
    #1;
    q_msb.delete();
    q_lsb.delete();
    chk("rst_out",   m_out,   1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_busy",  m_busy,  1'b0);
    chk("rst_done",  m_done,  1'b0);
    chk("rst_ready", m_ready, 1'b1);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    ser_hold  = 1'b0;
    #1;
    chk("init_out",   m_out,   1'b0);
    chk("init_valid", m_valid, 1'b0);
    chk("init_busy",  m_busy,  1'b0);
    chk("init_done",  m_done,  1'b0);
    chk("init_ready", m_ready, 1'b1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single word, one-cycle valid.
    cycle(1'b1, 8'hB5, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);

    // Back-to-back: second word held valid until taken in the done cycle.
    cycle(1'b1, 8'hB5, 1'b0);
    for (int i = 0; i < int'(W); i++) cycle(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b0);

    // Hold for 3 cycles while bit 3 is out; a valid word during hold is ignored.
    cycle(1'b1, 8'hB5, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);

    // Hold across the final bit delays the next accept.
    cycle(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < int'(W) - 1; i++) cycle(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC3, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);

    // Reset mid-frame after 4 bits, then a fresh word from bit 0.
    cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
    async_reset();
    cycle(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b0);

    // Random traffic with occasional holds and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset();
      cycle(logic'($urandom_range(0, 2) != 0), W'($urandom), logic'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
